// File: rtl/mac_array_sched.sv
//------------------------------------------------------------------------------
// Module  : mac_array_sched
// Brief   : Strobe/index sequencer for an N x N weight-stationary systolic MAC array.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mac_array_sched #(
  parameter int N         = 4,
  parameter int VW        = 8,
  parameter int DRAIN_LAT = 8
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 start,
  input  logic                 abort,
  input  logic [VW-1:0]        num_vec,
  output logic                 busy,
  output logic                 done,
  output logic                 w_rd,
  output logic [$clog2(N)-1:0] w_row,
  output logic [N-1:0]         load_row,
  output logic                 in_rd,
  output logic [VW-1:0]        in_idx,
  output logic [N-1:0]         en_top,
  output logic [N-1:0]         en_left,
  output logic                 out_valid,
  output logic [VW-1:0]        out_idx
);

  localparam int RW = $clog2(N);
  localparam logic [RW:0] C_W_LAST = (RW+1)'(N - 1);
  localparam logic [RW:0] C_W_END  = (RW+1)'(N);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_FEED   = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [VW-1:0]        r_num_vec;
  logic [VW-1:0]        r_in_cnt;
  logic [VW-1:0]        r_out_cnt;
  logic [RW:0]          r_w_cnt;
  logic [N-1:0]         r_load_row;
  logic [N-1:0]         r_en_top;
  logic [DRAIN_LAT-1:0] r_drain;
  logic                 w_rd_en;
  logic                 w_in_rd;
  logic                 w_out_valid;
  logic                 w_abort;
  logic                 w_job_empty;

  assign w_abort     = abort && (r_state != S_IDLE);
  assign w_job_empty = (r_num_vec == '0);
  assign w_rd_en     = (r_state == S_LOAD_W) && (r_w_cnt < C_W_END);
  assign w_in_rd     = (r_state == S_FEED);
  assign w_out_valid = r_drain[DRAIN_LAT-1];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD_W;
      S_LOAD_W: begin
        // An empty job lingers one extra cycle so the last load_row lands before done.
        if (w_job_empty) begin
          if (r_w_cnt == C_W_END) w_next = S_DONE;
        end else if (r_w_cnt == C_W_LAST) begin
          w_next = S_FEED;
        end
      end
      S_FEED:   if (r_in_cnt == r_num_vec - VW'(1)) w_next = S_DRAIN;
      S_DRAIN:  if (w_out_valid && (r_out_cnt == r_num_vec - VW'(1))) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state    <= S_IDLE;
      r_num_vec  <= '0;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_w_cnt    <= '0;
      r_load_row <= '0;
      r_en_top   <= '0;
      r_drain    <= '0;
    end else if (w_abort) begin
      r_state    <= S_IDLE;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_w_cnt    <= '0;
      r_load_row <= '0;
      r_en_top   <= '0;
      r_drain    <= '0;
    end else begin
      r_state    <= w_next;
      r_load_row <= w_rd_en ? (N'(1) << r_w_cnt[RW-1:0]) : '0;
      r_en_top   <= (r_en_top << 1) | N'(w_in_rd);
      r_drain    <= (r_drain << 1) | DRAIN_LAT'(r_en_top[N-1]);
      if ((r_state == S_IDLE) && start) begin
        r_num_vec <= num_vec;
        r_w_cnt   <= '0;
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (r_state == S_LOAD_W) r_w_cnt   <= r_w_cnt + (RW+1)'(1);
        if (w_in_rd)             r_in_cnt  <= r_in_cnt + VW'(1);
        if (w_out_valid)         r_out_cnt <= r_out_cnt + VW'(1);
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign w_rd      = w_rd_en;
  assign w_row     = r_w_cnt[RW-1:0];
  assign load_row  = r_load_row;
  assign in_rd     = w_in_rd;
  assign in_idx    = r_in_cnt;
  assign en_top    = r_en_top;
  assign en_left   = ((r_state == S_FEED) || (r_state == S_DRAIN)) ? '1 : '0;
  assign out_valid = w_out_valid;
  assign out_idx   = r_out_cnt;

endmodule

`default_nettype wire
